// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard with reserve/flush and a registered busy count.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iWrite,
  input  logic [ADDR_W-1:0] iAddrC,
  input  logic [DATA_W-1:0] iRegC,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [ADDR_W-1:0] iAddrB,
  output logic [DATA_W-1:0] oRegA,
  output logic [DATA_W-1:0] oRegB,
  input  logic              iReserve,
  input  logic [ADDR_W-1:0] iAddrR,
  input  logic              iFlush,
  output logic              oBusyA,
  output logic              oBusyB,
  output logic [ADDR_W-1:0] oBusyCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W-1:0] busy_count_reg;
  logic [ADDR_W-1:0] busy_count_next;
  logic              write_hit;
  logic              reserve_hit;

  assign write_hit   = iWrite && (iAddrC != '0);
  assign reserve_hit = iReserve && (iAddrR != '0);

  // Entry 0 is never written after reset; the read mux also forces it to zero.
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_hit) begin
      regs_reg[iAddrC] <= iRegC;
    end
  end

  // Reserve is applied after the write-clear so it wins on an address collision.
  always_comb begin
    busy_next = busy_reg;
    if (iFlush) begin
      busy_next = '0;
    end else begin
      if (write_hit) begin
        busy_next[iAddrC] = 1'b0;
      end
      if (reserve_hit) begin
        busy_next[iAddrR] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
    busy_count_next = ADDR_W'($countones(busy_next));
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  assign oBusyCount = busy_count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = (gi == 0) ? iAddrA : iAddrB;

      always_comb begin
        data = regs_reg[addr];
        busy = busy_reg[addr];
        if (addr == '0) begin
          data = '0;
          busy = 1'b0;
        end else if (BYPASS && iWrite && (iAddrC == addr)) begin
          data = iRegC;
          busy = 1'b0;
        end
      end
    end
  endgenerate

  assign oRegA  = g_rd[0].data;
  assign oBusyA = g_rd[0].busy;
  assign oRegB  = g_rd[1].data;
  assign oBusyB = g_rd[1].busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a forwarding and a non-forwarding instance
// share stimulus and are checked against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2 ** AW;

  logic          iClk = 1'b0;
  logic          nRst;
  logic          iWrite, iReserve, iFlush;
  logic [AW-1:0] iAddrC, iAddrA, iAddrB, iAddrR;
  logic [DW-1:0] iRegC;
  logic [DW-1:0] reg_a1, reg_b1, reg_a0, reg_b0;
  logic          busy_a1, busy_b1, busy_a0, busy_b0;
  logic [AW-1:0] count1, count0;

  always #5 iClk = ~iClk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut (
    .iClk(iClk), .nRst(nRst), .iWrite(iWrite), .iAddrC(iAddrC), .iRegC(iRegC),
    .iAddrA(iAddrA), .iAddrB(iAddrB), .oRegA(reg_a1), .oRegB(reg_b1),
    .iReserve(iReserve), .iAddrR(iAddrR), .iFlush(iFlush),
    .oBusyA(busy_a1), .oBusyB(busy_b1), .oBusyCount(count1)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nobyp (
    .iClk(iClk), .nRst(nRst), .iWrite(iWrite), .iAddrC(iAddrC), .iRegC(iRegC),
    .iAddrA(iAddrA), .iAddrB(iAddrB), .oRegA(reg_a0), .oRegB(reg_b0),
    .iReserve(iReserve), .iAddrR(iAddrR), .iFlush(iFlush),
    .oBusyA(busy_a0), .oBusyB(busy_b0), .oBusyCount(count0)
  );

  typedef struct {
    string     name;
    logic [DW-1:0] ra1, rb1, ra0, rb0;
    logic      ba1, bb1, ba0, bb0;
    logic [AW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  logic [DW-1:0] m_mem  [N];
  bit            m_busy [N];

  function automatic logic [DW-1:0] m_rd(int a, bit byp);
    if (a == 0) return '0;
    if (byp && iWrite && int'(iAddrC) == a) return iRegC;
    return m_mem[a];
  endfunction

  function automatic logic m_bz(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && iWrite && int'(iAddrC) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: compares each cycle's outputs once they have settled.
  always @(negedge iClk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " regA"},   reg_a1, e.ra1);
      check({e.name, " regB"},   reg_b1, e.rb1);
      check({e.name, " busyA"},  DW'(busy_a1), DW'(e.ba1));
      check({e.name, " busyB"},  DW'(busy_b1), DW'(e.bb1));
      check({e.name, " count"},  DW'(count1), DW'(e.cnt));
      check({e.name, " nb regA"},  reg_a0, e.ra0);
      check({e.name, " nb regB"},  reg_b0, e.rb0);
      check({e.name, " nb busyA"}, DW'(busy_a0), DW'(e.ba0));
      check({e.name, " nb busyB"}, DW'(busy_b0), DW'(e.bb0));
      check({e.name, " nb count"}, DW'(count0), DW'(e.cnt));
      $display("[TB] %s A=%0d B=%0d regA=%h regB=%h busyA=%0b busyB=%0b count=%0d",
               e.name, iAddrA, iAddrB, reg_a1, reg_b1, busy_a1, busy_b1, count1);
    end
  end

  // One clock of stimulus: drive, predict, let the edge happen, advance the model.
  task automatic cycle(string nm, bit rst_n, bit wr, int ac, logic [DW-1:0] dc,
                       int aa, int ab, bit rs, int ar, bit fl);
    exp_t e;
    nRst = rst_n; iWrite = wr; iAddrC = AW'(ac); iRegC = dc;
    iAddrA = AW'(aa); iAddrB = AW'(ab); iReserve = rs; iAddrR = AW'(ar); iFlush = fl;
    e.name = nm;
    e.ra1 = m_rd(aa, 1'b1); e.rb1 = m_rd(ab, 1'b1);
    e.ra0 = m_rd(aa, 1'b0); e.rb0 = m_rd(ab, 1'b0);
    e.ba1 = m_bz(aa, 1'b1); e.bb1 = m_bz(ab, 1'b1);
    e.ba0 = m_bz(aa, 1'b0); e.bb0 = m_bz(ab, 1'b0);
    e.cnt = AW'(m_count());
    exp_q.push_back(e);
    @(posedge iClk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr && ac != 0) m_mem[ac] = dc;
      if (fl) begin
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr && ac != 0) m_busy[ac] = 1'b0;
        if (rs && ar != 0) m_busy[ar] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    nRst = 1'b0; iWrite = 0; iAddrC = '0; iRegC = '0; iAddrA = '0; iAddrB = '0;
    iReserve = 0; iAddrR = '0; iFlush = 0;
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    // Unchecked reset edge brings the DUT out of its unknown power-up state
    @(posedge iClk);
    #1;

    for (int i = 0; i < N; i++)
      cycle("rst_read", 1, 0, 0, '0, i, N - 1 - i, 0, 0, 0);

    cycle("wr_r5",    1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle("rd_r5",    1, 0, 0, '0, 5, 0, 0, 0, 0);
    cycle("wr_r0",    1, 1, 0, 32'h1234, 0, 5, 0, 0, 0);
    cycle("rd_r0",    1, 0, 0, '0, 0, 0, 0, 0, 0);

    cycle("wr_r7",    1, 1, 7, 32'h11, 0, 0, 0, 0, 0);
    cycle("fwd_r7",   1, 1, 7, 32'h22, 7, 7, 0, 0, 0);
    cycle("rd_r7",    1, 0, 0, '0, 7, 0, 0, 0, 0);

    cycle("rsv_r3",   1, 0, 0, '0, 0, 0, 1, 3, 0);
    cycle("wr_rsv3",  1, 1, 3, 32'h33, 3, 0, 1, 3, 0);
    cycle("wr_r3",    1, 1, 3, 32'h34, 3, 3, 0, 0, 0);
    cycle("rd_r3",    1, 0, 0, '0, 3, 0, 0, 0, 0);

    cycle("rsv_r1",   1, 0, 0, '0, 1, 0, 1, 1, 0);
    cycle("rsv_r2",   1, 0, 0, '0, 1, 2, 1, 2, 0);
    cycle("rsv_r4",   1, 0, 0, '0, 2, 4, 1, 4, 0);
    cycle("rsv_r4x",  1, 0, 0, '0, 4, 0, 1, 4, 0);
    cycle("flush",    1, 0, 0, '0, 4, 6, 1, 6, 1);
    cycle("post_fl",  1, 0, 0, '0, 5, 6, 0, 0, 0);

    cycle("rsv_r9",   1, 0, 0, '0, 9, 0, 1, 9, 0);
    cycle("wr_r9",    1, 1, 9, 32'hA5, 9, 0, 1, 9, 0);
    cycle("rst_mid",  0, 1, 9, 32'h77, 9, 5, 1, 12, 0);
    cycle("post_rst", 1, 0, 0, '0, 9, 5, 0, 0, 0);

    for (int t = 0; t < 400; t++) begin
      bit rn = ($urandom_range(0, 49) != 0);
      bit wr = ($urandom_range(0, 1) == 1);
      int ac = $urandom_range(0, N - 1);
      bit rs = ($urandom_range(0, 2) != 0);
      int ar = ($urandom_range(0, 4) == 0) ? ac : $urandom_range(0, N - 1);
      int aa = ($urandom_range(0, 3) == 0) ? ac : $urandom_range(0, N - 1);
      int ab = ($urandom_range(0, 4) == 0) ? aa : $urandom_range(0, N - 1);
      bit fl = ($urandom_range(0, 19) == 0);
      cycle("rand", rn, wr, ac, DW'($urandom), aa, ab, rs, ar, fl);
    end

    cycle("idle", 1, 0, 0, '0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge iClk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 32, register data width in bits.
REQ-002 Parameter ADDR_W, 5, address width; depth = 2**ADDR_W registers, index 0 hardwired zero.
REQ-003 Parameter BYPASS, 1, 1 = same-cycle write forwarding and busy-clear forwarding on read ports; 0 = none.
REQ-004 iClk  in  1  single clock; all state updates on rising edge.
REQ-005 nRst  in  1  reset, synchronous, active-low.
REQ-006 iWrite  in  1  write enable for port C.
REQ-007 iAddrC  in  ADDR_W  write address.
REQ-008 iRegC  in  DATA_W  write data.
REQ-009 iAddrA, iAddrB  in  ADDR_W each  read addresses.
REQ-010 oRegA, oRegB  out  DATA_W each  read data, combinational.
REQ-011 iReserve  in  1  mark destination register busy (scoreboard set).
REQ-012 iAddrR  in  ADDR_W  reserve address.
REQ-013 iFlush  in  1  clear all busy bits.
REQ-014 oBusyA, oBusyB  out  1 each  busy status of iAddrA / iAddrB.
REQ-015 oBusyCount  out  ADDR_W  number of busy bits currently set, registered.

Function
REQ-016 Storage SHALL be 2**ADDR_W-1 registers of DATA_W bits (indices 1..N-1); index 0 SHALL read 0 always.
REQ-017 Write: on rising edge with nRst=1, iWrite=1, iAddrC!=0, reg[iAddrC] <= iRegC; iAddrC=0 writes SHALL be discarded.
REQ-018 Read: oRegX = 0 if iAddrX=0; else if BYPASS=1 and iWrite=1 and iAddrC=iAddrX, iRegC; else reg[iAddrX].
REQ-019 Both read ports SHALL be independent; same address on A and B returns identical data.
REQ-020 Busy bits busy[1..N-1] SHALL be registered; busy[0] constant 0.
REQ-021 Per-edge busy update, priority high to low: iFlush=1 -> all busy cleared (same-cycle reserve ignored); iReserve=1 and iAddrR!=0 -> busy[iAddrR] set; iWrite=1 and iAddrC!=0 -> busy[iAddrC] cleared.
REQ-022 Reserve and write to the same nonzero address in the same cycle: busy bit SHALL end set (reserve wins); data still written.
REQ-023 Reserve of an already-busy register SHALL leave it set (no nesting); write to a non-busy register SHALL be legal and leave it clear.
REQ-024 oBusyX = 0 if iAddrX=0; else if BYPASS=1 and iWrite=1 and iAddrC=iAddrX, 0; else busy[iAddrX]. iReserve/iFlush SHALL NOT affect oBusyX in the same cycle.
REQ-025 oBusyCount SHALL equal popcount of busy bits after each edge (one-cycle latency vs. the causing event); max value 2**ADDR_W-1, no overflow.
REQ-026 iFlush SHALL NOT modify register contents.

Reset
REQ-027 While nRst=0 at a rising edge: all registers <= 0, all busy bits <= 0, oBusyCount <= 0; writes, reserves, flushes that cycle ignored.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge regardless of pending reservations; combinational outputs then reflect cleared state (oRegX=0, oBusyX=0) except BYPASS forwarding of an active write.

Verification
REQ-029 Reset then read all addresses -> oRegA=oRegB=0, oBusyA=oBusyB=0, oBusyCount=0.
REQ-030 Write 32'hDEADBEEF to r5, next cycle iAddrA=5, iAddrB=0 -> oRegA=32'hDEADBEEF, oRegB=0; write 32'h1234 to r0 -> r0 still reads 0.
REQ-031 BYPASS=1: r7=32'h11, same cycle iWrite=1, iAddrC=7, iRegC=32'h22, iAddrA=7 -> oRegA=32'h22 that cycle; BYPASS=0 build -> oRegA=32'h11, then 32'h22 next cycle.
REQ-032 Reserve r3 -> next cycle oBusyA(3)=1, oBusyCount=1; write r3 with iReserve=1, iAddrR=3 same cycle -> busy[3] stays 1, count 1; write r3 alone -> count 0.
REQ-033 Reserve r1, r2, r4 on consecutive cycles -> count 1,2,3; iFlush=1 with iReserve=1, iAddrR=6 -> count 0, busy[6]=0, register data unchanged.
REQ-034 Reserve r9, write r9=32'hA5, then nRst=0 for one edge -> oBusyCount=0, r9 reads 0.
